// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester round-robin arbiter that time-shares one external ALU.
// Optional macro ALU_SHARE_ARB_BYPASS_EN: accept the next request in the cycle a response is taken.
module alu_share_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ReqValid0,
  output logic                      ReqReady0,
  input  logic [DATA_WIDTH-1:0]     ReqA0,
  input  logic [DATA_WIDTH-1:0]     ReqB0,
  input  logic [ALU_CTRL_WIDTH-1:0] ReqCtrl0,
  input  logic                      ReqValid1,
  output logic                      ReqReady1,
  input  logic [DATA_WIDTH-1:0]     ReqA1,
  input  logic [DATA_WIDTH-1:0]     ReqB1,
  input  logic [ALU_CTRL_WIDTH-1:0] ReqCtrl1,
  output logic                      RespValid0,
  input  logic                      RespReady0,
  output logic                      RespValid1,
  input  logic                      RespReady1,
  output logic [DATA_WIDTH-1:0]     RespResult,
  output logic                      RespZero,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  input  logic [DATA_WIDTH-1:0]     ALUResult,
  input  logic                      Zero
);

  // state | meaning
  // IDLE  | arbitrate between valid requesters, accept one operation
  // EXEC  | ALU evaluates the latched operands, result captured at the edge
  // RESP  | response held for the granted requester until it is taken
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                    state, state_nxt;
  logic                      ptr;
  logic                      gnt_id;
  logic [DATA_WIDTH-1:0]     op_a, op_b;
  logic [ALU_CTRL_WIDTH-1:0] op_ctrl;
  logic [DATA_WIDTH-1:0]     resp_result;
  logic                      resp_zero;
  logic                      sel1;
  logic                      both_valid;
  logic                      resp_take;
  logic                      accept_en;
  logic                      accept;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    sel1       = ReqValid1 & (~ReqValid0 | ptr);
    both_valid = ReqValid0 & ReqValid1;
    resp_take  = (state == RESP) & (gnt_id ? RespReady1 : RespReady0);
`ifdef ALU_SHARE_ARB_BYPASS_EN
    accept_en  = ~rst & ((state == IDLE) | resp_take);
`else
    accept_en  = ~rst & (state == IDLE);
`endif
    accept     = accept_en & (ReqValid0 | ReqValid1);
    ReqReady0  = accept_en & ReqValid0 & ~sel1;
    ReqReady1  = accept_en & sel1;
    RespValid0 = ~rst & (state == RESP) & ~gnt_id;
    RespValid1 = ~rst & (state == RESP) & gnt_id;
    state_nxt  = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_take) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer only moves under real contention so a lone requester never loses its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= 1'b0;
      gnt_id      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_ctrl     <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= sel1 ? ReqA1 : ReqA0;
        op_b    <= sel1 ? ReqB1 : ReqB0;
        op_ctrl <= sel1 ? ReqCtrl1 : ReqCtrl0;
        gnt_id  <= sel1;
        if (both_valid) ptr <= ~sel1;
      end
      if (state == EXEC) begin
        resp_result <= ALUResult;
        resp_zero   <= Zero;
      end
    end
  end

  assign SrcA       = op_a;
  assign SrcB       = op_b;
  assign ALUControl = op_ctrl;
  assign RespResult = resp_result;
  assign RespZero   = resp_zero;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural ALU and a response scoreboard.
// Honours ALU_SHARE_ARB_BYPASS_EN when checking accept spacing.
module tb_alu_share_arb;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ReqValid0, ReqReady0, ReqValid1, ReqReady1;
  logic [DW-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic [CW-1:0] ReqCtrl0, ReqCtrl1;
  logic          RespValid0, RespReady0, RespValid1, RespReady1;
  logic [DW-1:0] RespResult;
  logic          RespZero;
  logic [DW-1:0] SrcA, SrcB, ALUResult;
  logic [CW-1:0] ALUControl;
  logic          Zero;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] res;
    logic          z;
  } exp_t;

  exp_t sb[$];
  logic acc_id[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   resp_cnt = 0;
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0), .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqCtrl0(ReqCtrl0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1), .ReqA1(ReqA1), .ReqB1(ReqB1), .ReqCtrl1(ReqCtrl1),
    .RespValid0(RespValid0), .RespReady0(RespReady0),
    .RespValid1(RespValid1), .RespReady1(RespReady1),
    .RespResult(RespResult), .RespZero(RespZero),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [CW-1:0] c);
    case (c)
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? {DW{1'b1}} : {DW{1'b0}};
      default: return a + b;
    endcase
  endfunction

  assign ALUResult = alu_f(SrcA, SrcB, ALUControl);
  assign Zero      = (SrcA == SrcB);

  // Response monitor: every cycle a response is visible it must match the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      sb.delete();
    end else begin
      checks++;
      if (ReqReady0 && ReqReady1) begin
        errors++;
        $display("FAIL dual_ready: ReqReady0=%0b ReqReady1=%0b, want at most one", ReqReady0, ReqReady1);
      end
      if (RespValid0 || RespValid1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: RespValid0=%0b RespValid1=%0b with nothing outstanding",
                   RespValid0, RespValid1);
        end else begin
          mon_e = sb[0];
          if ({RespValid1, RespValid0} !== {mon_e.id, ~mon_e.id} ||
              RespResult !== mon_e.res || RespZero !== mon_e.z) begin
            errors++;
            $display("FAIL resp_data: got v1v0=%b res=%h z=%b, want v1v0=%b res=%h z=%b",
                     {RespValid1, RespValid0}, RespResult, RespZero,
                     {mon_e.id, ~mon_e.id}, mon_e.res, mon_e.z);
          end
          if (mon_e.id ? RespReady1 : RespReady0) begin
            void'(sb.pop_front());
            resp_cnt++;
          end
        end
      end
    end
  end

  // Called right after a negedge; returns at the negedge following the accepting edge, valid still high.
  task automatic issue(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [CW-1:0] c, input logic [DW-1:0] er, input logic ez);
    int   n;
    exp_t t;
    if (id == 1'b0) begin ReqValid0 = 1'b1; ReqA0 = a; ReqB0 = b; ReqCtrl0 = c; end
    else            begin ReqValid1 = 1'b1; ReqA1 = a; ReqB1 = b; ReqCtrl1 = c; end
    n = 0;
    forever begin
      #1;
      if ((id == 1'b0) ? ReqReady0 : ReqReady1) begin
        t.id = id; t.res = er; t.z = ez;
        sb.push_back(t);
        acc_id.push_back(id);
        acc_cyc.push_back(cyc);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL issue_timeout: req%0d never saw ReqReady within 50 cycles", id);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    #1;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding, want 0", sb.size());
    end
    @(negedge clk); #1;
    checks++;
    if (RespValid0 !== 1'b0 || RespValid1 !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: RespValid0=%0b RespValid1=%0b, want 0 0", RespValid0, RespValid1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ReqValid0 = 1'b1; ReqA0 = 32'd5; ReqB0 = 32'd7; ReqCtrl0 = 3'b000;
    ReqValid1 = 1'b1; ReqA1 = 32'd1; ReqB1 = 32'd1; ReqCtrl1 = 3'b000;
    RespReady0 = 1'b1; RespReady1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ReqReady0 !== 1'b0 || ReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b %0b, want 0 0", ReqReady0, ReqReady1);
    end
    checks++;
    if (RespValid0 !== 1'b0 || RespValid1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_respvalid: got %0b %0b, want 0 0", RespValid0, RespValid1);
    end
    checks++;
    if (SrcA !== '0 || SrcB !== '0 || ALUControl !== 3'b000 || RespResult !== '0 || RespZero !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: SrcA=%h SrcB=%h ctrl=%b res=%h z=%b, want all 0",
               SrcA, SrcB, ALUControl, RespResult, RespZero);
    end
    ReqValid1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    exp_t t;
    rst = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd5; ReqB0 = 32'd7; ReqCtrl0 = 3'b000;
    #1;
    checks++;
    if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_c1: ReqReady0=%0b ReqReady1=%0b, want 1 0", ReqReady0, ReqReady1);
    end
    t.id = 1'b0; t.res = 32'd12; t.z = 1'b0;
    sb.push_back(t);
    @(negedge clk);
    ReqValid0 = 1'b0;
    #1;
    checks++;
    if (RespValid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_c2: RespValid0=%0b, want 0", RespValid0);
    end
    @(negedge clk); #1;
    checks++;
    if (RespValid0 !== 1'b1 || RespValid1 !== 1'b0 || RespResult !== 32'd12 || RespZero !== 1'b0) begin
      errors++;
      $display("FAIL single_c3: v0=%0b v1=%0b res=%0d z=%0b, want 1 0 12 0",
               RespValid0, RespValid1, RespResult, RespZero);
    end
    @(negedge clk); #1;
    checks++;
    if (RespValid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_c4: RespValid0=%0b, want 0", RespValid0);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    acc_id.delete(); acc_cyc.delete();
    fork
      begin
        issue(1'b0, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1);
        issue(1'b0, 32'd9, 32'd9, 3'b001, 32'd0, 1'b1);
        ReqValid0 = 1'b0;
      end
      begin
        issue(1'b1, 32'h0F0, 32'h00F, 3'b011, 32'hFF, 1'b0);
        issue(1'b1, 32'h0F0, 32'h00F, 3'b011, 32'hFF, 1'b0);
        ReqValid1 = 1'b0;
      end
    join
    drain();
    checks++;
    if (acc_id.size() != 4) begin
      errors++;
      $display("FAIL rr_count: %0d grants, want 4", acc_id.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_id[i] !== ((i % 2) == 1)) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got req%0d, want req%0d", i, acc_id[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    RespReady1 = 1'b0;
    issue(1'b1, 32'hFF00FF00, 32'h0FF00FF0, 3'b010, 32'h0F000F00, 1'b0);
    ReqValid1 = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd1; ReqB0 = 32'd2; ReqCtrl0 = 3'b000;
    #1;
    checks++;
    if (ReqReady0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_exec_ready0: got %0b, want 0", ReqReady0);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (RespValid1 !== 1'b1 || RespResult !== 32'h0F000F00 || ReqReady0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v1=%0b res=%h rdy0=%0b, want 1 0f000f00 0",
                 i, RespValid1, RespResult, ReqReady0);
      end
      @(negedge clk);
    end
    RespReady1 = 1'b1;
    issue(1'b0, 32'd1, 32'd2, 3'b000, 32'd3, 1'b0);
    ReqValid0 = 1'b0;
    drain();
  endtask

  task automatic test_slt();
    int            n;
    logic [DW-1:0] a, b, er;
    for (int i = 0; i < 2; i++) begin
      a  = (i == 0) ? 32'd3 : 32'd8;
      b  = (i == 0) ? 32'd8 : 32'd3;
      er = (i == 0) ? 32'hFFFFFFFF : 32'd0;
      issue(1'b0, a, b, 3'b101, er, 1'b0);
      ReqValid0 = 1'b0;
      n = 0;
      #1;
      while (RespValid0 !== 1'b1 && n < 10) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      if (RespValid0 !== 1'b1 || RespResult !== er) begin
        errors++;
        $display("FAIL slt[%0d]: v0=%0b res=%h, want 1 %h", i, RespValid0, RespResult, er);
      end
      @(negedge clk);
    end
    drain();
  endtask

  task automatic test_reset_exec();
    exp_t t;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ReqValid0 = 1'b1; ReqA0 = 32'd10; ReqB0 = 32'd10; ReqCtrl0 = 3'b000;
    ReqValid1 = 1'b1; ReqA1 = 32'd1;  ReqB1 = 32'd2;  ReqCtrl1 = 3'b000;
    #1;
    checks++;
    if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_grant: rdy0=%0b rdy1=%0b, want 1 0", ReqReady0, ReqReady1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (RespValid0 !== 1'b0 || RespValid1 !== 1'b0 || ReqReady0 !== 1'b0 || ReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_exec: v0=%0b v1=%0b rdy0=%0b rdy1=%0b, want all 0",
               RespValid0, RespValid1, ReqReady0, ReqReady1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ReqReady0 !== 1'b1 || ReqReady1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_post_grant: rdy0=%0b rdy1=%0b, want 1 0", ReqReady0, ReqReady1);
    end
    checks++;
    if (RespValid0 !== 1'b0 || RespValid1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp: v0=%0b v1=%0b, want 0 0", RespValid0, RespValid1);
    end
    t.id = 1'b0; t.res = 32'd20; t.z = 1'b1;
    sb.push_back(t);
    @(negedge clk);
    ReqValid0 = 1'b0;
    issue(1'b1, 32'd1, 32'd2, 3'b000, 32'd3, 1'b0);
    ReqValid1 = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int gap;
`ifdef ALU_SHARE_ARB_BYPASS_EN
    gap = 2;
`else
    gap = 3;
`endif
    acc_id.delete(); acc_cyc.delete();
    RespReady0 = 1'b1;
    issue(1'b0, 32'd1, 32'd1, 3'b000, 32'd2, 1'b1);
    issue(1'b0, 32'd2, 32'd2, 3'b000, 32'd4, 1'b1);
    ReqValid0 = 1'b0;
    drain();
    checks++;
    if (acc_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: %0d accepts, want 2", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != gap) begin
      errors++;
      $display("FAIL b2b_gap: accept spacing %0d cycles, want %0d", acc_cyc[1] - acc_cyc[0], gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ReqValid0 = 1'b0; ReqA0 = '0; ReqB0 = '0; ReqCtrl0 = '0;
    ReqValid1 = 1'b0; ReqA1 = '0; ReqB1 = '0; ReqCtrl1 = '0;
    RespReady0 = 1'b0; RespReady1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_slt();
    test_reset_exec();
    test_back_to_back();
    checks++;
    if (resp_cnt != 13) begin
      errors++;
      $display("FAIL resp_total: %0d responses taken, want 13", resp_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer that shares one `alu` instance between two clients, e.g. the main execute path (req0) and an address or branch helper (req1).
- Accepts one operation at a time through a valid/ready handshake and drives the external ALU from registered operands.
- Captures ALUResult/Zero into a response register and holds the response until the granted requester accepts it.
- Sits between the requesters and the `alu` ports SrcA/SrcB/ALUControl/ALUResult/Zero.

Parameters:
- DATA_WIDTH, 32, operand and result width; must match the ALU.
- ALU_CTRL_WIDTH, 3, ALU control code width; must match the ALU.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ReqValid0  input  1  requester 0 has an operation.
- ReqReady0  output  1  arbiter accepts requester 0 this cycle.
- ReqA0  input  DATA_WIDTH  requester 0 operand A.
- ReqB0  input  DATA_WIDTH  requester 0 operand B.
- ReqCtrl0  input  ALU_CTRL_WIDTH  requester 0 ALU control code.
- ReqValid1, ReqReady1, ReqA1, ReqB1, ReqCtrl1: same as above, for requester 1.
- RespValid0  output  1  response pending for requester 0.
- RespReady0  input  1  requester 0 consumes its response.
- RespValid1  output  1  response pending for requester 1.
- RespReady1  input  1  requester 1 consumes its response.
- RespResult  output  DATA_WIDTH  registered ALU result, shared by both requesters.
- RespZero  output  1  registered ALU Zero flag.
- SrcA  output  DATA_WIDTH  to ALU.
- SrcB  output  DATA_WIDTH  to ALU.
- ALUControl  output  ALU_CTRL_WIDTH  to ALU.
- ALUResult  input  DATA_WIDTH  from ALU.
- Zero  input  1  from ALU.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. Reset is sampled on the clk rising edge only.
- Reset values:
  - State = IDLE.
  - Priority pointer favours req0.
  - Operand registers, RespResult and RespZero = 0.
  - ALU control register = 3'b000.
  - All RespValid and ReqReady = 0 in the reset cycle.
  - SrcA, SrcB and ALUControl come straight from the operand registers, so they are 0 after reset.
- State machine, three states: IDLE, EXEC, RESP.
- IDLE:
  - ReqReadyN = 1 only for the requester selected by arbitration; the other is 0.
  - ReqReady depends only on state, pointer and ReqValid. It never depends on its own handshake.
  - If any ReqValid is high, the grant goes to the valid requester.
  - If both are valid, the grant goes to the one favoured by the pointer.
  - On the handshake: latch A, B, Ctrl and the grant id, then move to EXEC.
  - The pointer flips to favour the non-granted requester, but only when both were valid.
- EXEC (exactly one cycle): the ALU sees the latched operands. At the clock edge, RespResult <= ALUResult and RespZero <= Zero; go to RESP.
- RESP:
  - RespValidN = 1 only for the granted id.
  - Hold RespResult and RespZero stable until RespReadyN is high; then return to IDLE.
  - RespReady of the non-granted requester is ignored.
- Latency and throughput:
  - Handshake in cycle t; RespValid is high from cycle t+2.
  - With RespReady held high, the response completes in cycle t+2 and the next accept is in cycle t+3.
  - Throughput is 1 operation per 3 cycles.
- ReqReady is 0 in EXEC and RESP. Requests must hold their valid and payload until accepted.
- An unknown Ctrl code is forwarded unchanged. Decoding is the ALU's job (it defaults to add).
- Zero semantics are exactly as the ALU provides (A equals B), independent of Ctrl.
- Reset mid-operation (in EXEC or RESP): the operation is dropped, no response is produced, and the pointer returns to req0.
- Operand registers are unchanged outside the accept cycle.

Optional Feature:
- Macro: ALU_SHARE_ARB_BYPASS_EN.
- When defined:
  - In RESP, if RespReady is high, return to IDLE behaviour in the same cycle: ReqReady may assert and a new request may be accepted, going straight to EXEC.
  - Throughput becomes 1 operation per 2 cycles.
  - The arbitration rules are unchanged.
  - ReqReady may then depend combinationally on RespReady.
- When undefined: the strict 3-cycle behaviour above.

Test Plan:
- Reset then single request: req0 sends A=5, B=7, Ctrl=000, RespReady0=1.
  - ReqReady0 is high in cycle 1.
  - RespValid0 is high in cycle 3 with RespResult=12 and RespZero=0.
  - RespValid1 stays 0.
- Contention, round robin: both valid every cycle.
  - req0 sends sub, A=9, B=9, expect result 0 and Zero=1.
  - req1 sends or, A=0xF0, B=0x0F, expect 0xFF.
  - Grants must be 0, 1, 0, 1 across four operations.
- Backpressure: req1 sends and, A=0xFF00FF00, B=0x0FF00FF0, with RespReady1 low for 5 cycles.
  - RespValid1 is held and RespResult stays at 0x0F000F00 the whole time.
  - ReqReady0 stays 0 while req0 is pending.
- Set-less-than: req0 sends Ctrl=101, A=3, B=8, expect 0xFFFFFFFF; then A=8, B=3, expect 0.
- Reset in EXEC: assert rst in the cycle after accept.
  - No RespValid appears.
  - The next simultaneous requests grant req0 first.
- ALU_SHARE_ARB_BYPASS_EN defined: with back-to-back req0 adds and RespReady0=1, there are accepts every 2 cycles.
  - Results are 1+1=2, then 2+2=4.
